// File: rtl/mma_icb_rr_arbiter.sv
// Round-robin owner arbitration for the MMA shared ICB master port, with an urgent class and a tenure watchdog.
// Grant is registered one cycle after request; the owner holds it until done, abort, flush or timeout, then one dead cycle.
module mma_icb_rr_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int SEL_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_WIDTH       = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   urgent,
  input  logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   granted,
  output logic [SEL_WIDTH-1:0] icb_sel,
  output logic                 bus_busy,
  output logic                 timeout_err,
  output logic [SEL_WIDTH-1:0] timeout_id
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_e;

  localparam logic [SEL_WIDTH-1:0] SEL_IDLE = '1;
  localparam logic [SEL_WIDTH-1:0] PTR_RST  = SEL_WIDTH'(NUM_REQ - 1);
  localparam logic [TO_WIDTH-1:0]  TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic                 TO_EN    = (TIMEOUT_CYCLES != 0);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   granted_q, granted_d;
  logic [SEL_WIDTH-1:0] icb_sel_q, icb_sel_d;
  logic [SEL_WIDTH-1:0] last_ptr_q, last_ptr_d;
  logic [TO_WIDTH-1:0]  cnt_q, cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [SEL_WIDTH-1:0] timeout_id_q, timeout_id_d;

  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   cand_hi;
  logic                 win_vld;
  logic [SEL_WIDTH-1:0] win_idx;

  logic own_req;
  logic own_done;
  logic tmo_hit;
  logic rel_any;

  // Urgent requesters form their own pool; the rotation starts just above last_ptr
  // and falls back to the lowest index when nothing above it is pending.
  always_comb begin
    cand    = (|(req & urgent)) ? (req & urgent) : req;
    cand_hi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_hi[i] = cand[i] && (SEL_WIDTH'(i) > last_ptr_q);
    end
    win_vld = |cand;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = SEL_WIDTH'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_hi[i]) win_idx = SEL_WIDTH'(i);
    end
  end

  assign own_req  = |(granted_q & req);
  assign own_done = |(granted_q & done);
  assign tmo_hit  = TO_EN && (cnt_q == TO_LAST);
  assign rel_any  = flush || !own_req || own_done || tmo_hit;

  always_comb begin
    state_d       = state_q;
    granted_d     = granted_q;
    icb_sel_d     = icb_sel_q;
    last_ptr_d    = last_ptr_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    timeout_id_d  = timeout_id_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!flush && win_vld) begin
          state_d    = ST_GRANT;
          granted_d  = NUM_REQ'(1) << win_idx;
          icb_sel_d  = win_idx;
          last_ptr_d = win_idx;
          cnt_d      = '0;
        end
      end
      ST_GRANT: begin
        if (rel_any) begin
          state_d   = ST_RELEASE;
          granted_d = '0;
          icb_sel_d = SEL_IDLE;
          // Only a pure watchdog expiry is an error; flush, abort and done all win over it.
          if (!flush && own_req && !own_done) begin
            timeout_err_d = 1'b1;
            timeout_id_d  = icb_sel_q;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        granted_d = '0;
        icb_sel_d = SEL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      granted_q     <= '0;
      icb_sel_q     <= SEL_IDLE;
      last_ptr_q    <= PTR_RST;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      state_q       <= state_d;
      granted_q     <= granted_d;
      icb_sel_q     <= icb_sel_d;
      last_ptr_q    <= last_ptr_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
    end
  end

  assign granted     = granted_q;
  assign icb_sel     = icb_sel_q;
  assign bus_busy    = (state_q != ST_IDLE);
  assign timeout_err = timeout_err_q;
  assign timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_mma_icb_rr_arbiter.sv
// Scoreboard bench for mma_icb_rr_arbiter: an ownership-level model queues expected outputs per cycle,
// a negedge monitor pops and compares them alongside grant-order and timeout-pulse checks.
module tb_mma_icb_rr_arbiter;
  localparam int N  = 5;
  localparam int SW = 3;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [N-1:0]  req;
  logic [N-1:0]  urgent;
  logic [N-1:0]  done;
  logic [N-1:0]  granted;
  logic [SW-1:0] icb_sel;
  logic          bus_busy;
  logic          timeout_err;
  logic [SW-1:0] timeout_id;

  mma_icb_rr_arbiter #(
    .NUM_REQ(N), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(13)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .req(req), .urgent(urgent), .done(done),
    .granted(granted), .icb_sel(icb_sel), .bus_busy(bus_busy),
    .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  granted;
    logic [SW-1:0] sel;
    logic          busy;
    logic          terr;
    logic [SW-1:0] tid;
  } exp_t;

  exp_t exp_q[$];
  int   order_q[$];
  int   total = 0;
  int   bad = 0;
  int   terr_cnt = 0;
  bit   mon_en = 1'b0;
  logic [N-1:0] prev_gnt = '0;

  // Model: phase 0 = bus free, 1 = owned, 2 = dead cycle; owner -1 when nobody holds the bus.
  int m_phase = 0;
  int m_owner = -1;
  int m_last = N - 1;
  int m_tenure = 0;
  int m_tid = 0;
  bit m_terr = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] pool);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (pool[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_step(input bit r, input bit f, input logic [N-1:0] rq,
                                     input logic [N-1:0] ug, input logic [N-1:0] dn);
    int w;
    if (r) begin
      m_phase = 0; m_owner = -1; m_last = N - 1; m_tenure = 0; m_terr = 1'b0; m_tid = 0;
      return;
    end
    m_terr = 1'b0;
    if (m_phase == 0) begin
      if (!f && rq != '0) begin
        w = rr_pick(rq & ug);
        if (w < 0) w = rr_pick(rq);
        m_owner = w; m_last = w; m_tenure = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (f || !rq[m_owner] || dn[m_owner]) begin
        m_owner = -1; m_phase = 2;
      end else if (m_tenure == TO - 1) begin
        m_terr = 1'b1; m_tid = m_owner; m_owner = -1; m_phase = 2;
      end else begin
        m_tenure++;
      end
    end else begin
      m_phase = 0;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.granted = '0;
    e.sel     = '1;
    if (m_owner >= 0) begin
      e.granted = N'(1) << m_owner;
      e.sel     = SW'(m_owner);
    end
    e.busy = (m_phase != 0);
    e.terr = m_terr;
    e.tid  = SW'(m_tid);
    return e;
  endfunction

  function automatic logic [N-1:0] dn_after1();
    if (m_phase == 1 && m_tenure == 1) return N'(1) << m_owner;
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit f, input logic [N-1:0] rq,
                     input logic [N-1:0] ug, input logic [N-1:0] dn);
    rst = r; flush = f; req = rq; urgent = ug; done = dn;
    model_step(r, f, rq, ug, dn);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) cyc(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_owner(input int who, input logic [N-1:0] rq, input logic [N-1:0] ug);
    for (int n = 0; n < 20; n++) begin
      if (m_phase == 1 && m_owner == who) break;
      cyc(1'b0, 1'b0, rq, ug, '0);
    end
  endtask

  task automatic check_order(input string nm, input int n, input int a0, input int a1,
                             input int a2, input int a3, input int a4, input int a5);
    int ev[6];
    ev = '{a0, a1, a2, a3, a4, a5};
    for (int i = 0; i < n; i++) begin
      chk(nm, (i < order_q.size()) ? order_q[i] : -1, ev[i]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("granted", granted, e.granted);
        chk("icb_sel", icb_sel, e.sel);
        chk("bus_busy", bus_busy, e.busy);
        chk("timeout_err", timeout_err, e.terr);
        chk("timeout_id", timeout_id, e.tid);
      end
      chk("onehot", $countones(granted) <= 1, 1);
      chk("sel_matches_grant", (granted == '0) || (granted == (N'(1) << icb_sel)), 1);
      if (granted != '0 && prev_gnt == '0) begin
        for (int i = 0; i < N; i++) if (granted[i]) order_q.push_back(i);
      end
      if (timeout_err) terr_cnt++;
      prev_gnt = granted;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0] cur_req;
    mon_en = 1'b1;

    // Reset, then full rotation with done one cycle after each grant.
    cyc(1'b1, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b0, 5'b11111, '0, '0);
    order_q.delete();
    repeat (30) cyc(1'b0, 1'b0, 5'b11111, '0, dn_after1());
    settle();
    check_order("order_rotation", 6, 0, 1, 2, 3, 4, 0);
    drain();

    // Urgent client 4 overtakes client 0 after client 1 releases.
    order_q.delete();
    wait_owner(1, 5'b00010, '0);
    repeat (2) cyc(1'b0, 1'b0, 5'b10011, 5'b10000, '0);
    cyc(1'b0, 1'b0, 5'b10011, 5'b10000, 5'b00010);
    wait_owner(4, 5'b10001, 5'b10000);
    cyc(1'b0, 1'b0, 5'b10001, 5'b10000, 5'b10000);
    repeat (6) cyc(1'b0, 1'b0, 5'b00001, '0, dn_after1());
    settle();
    check_order("order_urgent", 3, 1, 4, 0, 0, 0, 0);
    drain();

    // Watchdog: client 2 never signals done.
    settle();
    terr_cnt = 0;
    repeat (12) cyc(1'b0, 1'b0, 5'b00100, '0, '0);
    drain();
    settle();
    chk("timeout_pulses", terr_cnt, 1);
    chk("timeout_id_hold", timeout_id, 2);

    // Abort by dropping req[3]; rotation continues from 4.
    terr_cnt = 0;
    order_q.delete();
    wait_owner(3, 5'b01000, '0);
    cyc(1'b0, 1'b0, 5'b01000, '0, '0);
    cyc(1'b0, 1'b0, 5'b10001, '0, '0);
    repeat (14) cyc(1'b0, 1'b0, 5'b10001, '0, dn_after1());
    settle();
    check_order("order_abort", 3, 3, 4, 0, 0, 0, 0);
    chk("abort_no_timeout", terr_cnt, 0);
    drain();

    // Reset mid-tenure of client 1; first grant afterwards goes to client 0.
    wait_owner(1, 5'b00010, '0);
    cyc(1'b0, 1'b0, 5'b00010, '0, '0);
    cyc(1'b1, 1'b0, 5'b11111, '0, '0);
    order_q.delete();
    repeat (8) cyc(1'b0, 1'b0, 5'b11111, '0, dn_after1());
    settle();
    check_order("order_after_reset", 2, 0, 1, 0, 0, 0, 0);
    drain();

    // flush coincides with done and watchdog expiry; then flush in IDLE blocks one grant.
    settle();
    terr_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (m_phase == 1 && m_owner == 0 && m_tenure == TO - 1) break;
      cyc(1'b0, 1'b0, 5'b00001, '0, '0);
    end
    cyc(1'b0, 1'b1, 5'b00001, '0, 5'b00001);
    drain();
    cyc(1'b0, 1'b1, 5'b00100, '0, '0);
    repeat (3) cyc(1'b0, 1'b0, 5'b00100, '0, '0);
    drain();
    settle();
    chk("flush_no_timeout", terr_cnt, 0);

    // Randomized traffic with sticky requests, occasional flush and reset.
    cur_req = '0;
    for (int n = 0; n < 1500; n++) begin
      cur_req ^= N'($urandom) & N'($urandom) & N'($urandom);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, cur_req,
          N'($urandom) & N'($urandom), N'($urandom) & N'($urandom) & N'($urandom));
    end

    settle();
    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
